// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for pio_in_edge_irq.
// Groups the word address, select, write strobe and data paths so the
// PIO and its host connect through a single port.
interface pio_in_edge_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Parametrised Avalon-MM input PIO with synchroniser, per-bit rising/falling
// edge selection, set-priority edge capture and a masked, registered IRQ.
// Optional per-bit debounce filter is enabled by defining PIO_DEBOUNCE_EN;
// without it the filtered value is simply the synchronised input.
//
// Register map (word address):
//   0 DATA (RO), 1 RISE_EN, 2 IRQ_MASK, 3 EDGE_CAPTURE (W1C), 4 FALL_EN,
//   5..7 read as zero.
module pio_in_edge_irq #(
  parameter int               WIDTH           = 4,
  parameter logic [WIDTH-1:0] RESET_RISE_MASK = '1,
  parameter logic [WIDTH-1:0] RESET_FALL_MASK = '1,
  parameter int               DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  pio_in_edge_irq_if.slave    bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_capture;
  logic [WIDTH-1:0] edge_det, clr_bits, rd_mux;
  logic [WIDTH-1:0] wdata;
  logic             wr;

  assign wr    = bus.chipselect && !bus.write_n;
  assign wdata = bus.writedata[WIDTH-1:0];

  // Two-flop synchroniser on the raw inputs, plus a delayed copy of the
  // filtered value used as the "previous" sample for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= filt;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0]    db_cnt [WIDTH];
  logic [WIDTH-1:0] filt_r;

  // Per-bit debounce: a bit only follows s2 after it has differed from the
  // filtered value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
      filt_r <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt_r[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_r[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign filt = filt_r;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_CYCLES == 0);
  assign filt = s2;
`endif

  // Edge events qualified by the per-bit enables, and the W1C clear vector.
  always_comb begin
    edge_det = (filt & ~s3 & rise_en) | (~filt & s3 & fall_en);
    clr_bits = '0;
    if (wr && bus.address == 3'd3) clr_bits = wdata;
  end

  // Control registers and edge capture; a fresh edge wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en      <= RESET_RISE_MASK;
      fall_en      <= RESET_FALL_MASK;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr && bus.address == 3'd1) rise_en  <= wdata;
      if (wr && bus.address == 3'd2) irq_mask <= wdata;
      if (wr && bus.address == 3'd4) fall_en  <= wdata;
      edge_capture <= edge_det | (edge_capture & ~clr_bits);
    end
  end

  // Read multiplexer; unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux = filt;
      3'd1:    rd_mux = rise_en;
      3'd2:    rd_mux = irq_mask;
      3'd3:    rd_mux = edge_capture;
      3'd4:    rd_mux = fall_en;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data (one-cycle latency, no chipselect qualification)
  // and the registered level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= 32'(rd_mux);
      irq          <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq (WIDTH=4): a table of register
// accesses, hand-written latency/priority/mask sequences, and a randomised
// run compared against a cycle-level reference model of the register map.
module tb_pio_in_edge_irq;

`ifdef PIO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_port = 4'h0;
  logic       irq;

  int check_count = 0;
  int error_count = 0;

  pio_in_edge_irq_if bus_if ();

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: input samples taken at each clock edge, newest first.
  // The value visible as DATA is the sample from two edges ago.
  logic [3:0]  hist[$];
  logic [3:0]  m_rise, m_fall, m_mask, m_cap;
  logic [31:0] m_rd;
  logic        m_irq;

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [3:0]  inp;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  task automatic resetModel();
    hist   = {4'h0, 4'h0, 4'h0};
    m_rise = 4'hF;
    m_fall = 4'hF;
    m_mask = 4'h0;
    m_cap  = 4'h0;
    m_rd   = 32'h0;
    m_irq  = 1'b0;
  endtask

  task automatic doReset();
    reset_n           = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
    in_port           = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    resetModel();
  endtask

  // Drive one bus cycle, advance the model across the coming clock edge,
  // then wait until just after that edge.
  task automatic applyStimulus(input logic [2:0] a, input logic cs, input logic wn,
                               input logic [31:0] wd, input logic [3:0] inp);
    logic [3:0] cur, prev, ev;
    logic       wr;
    bus_if.address    = a;
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.writedata  = wd;
    in_port           = inp;
    wr   = cs && !wn;
    cur  = hist[1];
    prev = hist[2];
    ev   = 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (cur[b] && !prev[b] && m_rise[b]) ev[b] = 1'b1;
      if (!cur[b] && prev[b] && m_fall[b]) ev[b] = 1'b1;
    end
    case (a)
      3'd0:    m_rd = {28'h0, cur};
      3'd1:    m_rd = {28'h0, m_rise};
      3'd2:    m_rd = {28'h0, m_mask};
      3'd3:    m_rd = {28'h0, m_cap};
      3'd4:    m_rd = {28'h0, m_fall};
      default: m_rd = 32'h0;
    endcase
    m_irq = (m_cap & m_mask) != 4'h0;
    for (int b = 0; b < 4; b++) begin
      if (ev[b])                          m_cap[b] = 1'b1;
      else if (wr && a == 3'd3 && wd[b])  m_cap[b] = 1'b0;
    end
    if (wr && a == 3'd1) m_rise = wd[3:0];
    if (wr && a == 3'd2) m_mask = wd[3:0];
    if (wr && a == 3'd4) m_fall = wd[3:0];
    hist.push_front(inp);
    void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_rd, input logic exp_irq);
    check_count++;
    if (bus_if.readdata !== exp_rd) begin
      error_count++;
      $display("[TB] FAIL %s readdata: got 0x%08h, required 0x%08h", name, bus_if.readdata, exp_rd);
    end
    check_count++;
    if (irq !== exp_irq) begin
      error_count++;
      $display("[TB] FAIL %s irq: got %0b, required %0b", name, irq, exp_irq);
    end
  endtask

  initial begin
    resetModel();
    doReset();
    checkOutput("reset", 32'h0, 1'b0);

`ifdef PIO_DEBOUNCE_EN
    // Short glitch must be filtered, a steady level must pass.
    for (int i = 0; i < 5; i++)  applyStimulus(3'd0, 1'b0, 1'b1, 32'h0, 4'h1);
    for (int i = 0; i < 20; i++) applyStimulus(3'd0, 1'b0, 1'b1, 32'h0, 4'h0);
    checkOutput("db_glitch_data", 32'h0, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h0);
    checkOutput("db_glitch_cap", 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(3'd0, 1'b0, 1'b1, 32'h0, 4'h1);
    checkOutput("db_steady_data", 32'h1, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h1);
    checkOutput("db_steady_cap", 32'h1, 1'b0);
`else
    // Register-map table: reset values, RW registers, ignored writes.
    vecs[0]  = '{3'd1, 1'b0, 1'b1, 32'h0,        4'h0, 32'hF, 1'b0};
    vecs[1]  = '{3'd4, 1'b0, 1'b1, 32'h0,        4'h0, 32'hF, 1'b0};
    vecs[2]  = '{3'd2, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[3]  = '{3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[4]  = '{3'd3, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[5]  = '{3'd2, 1'b1, 1'b0, 32'h1,        4'h0, 32'h0, 1'b0};
    vecs[6]  = '{3'd2, 1'b0, 1'b1, 32'h0,        4'h0, 32'h1, 1'b0};
    vecs[7]  = '{3'd1, 1'b1, 1'b0, 32'hFFFFFFF5, 4'h0, 32'hF, 1'b0};
    vecs[8]  = '{3'd1, 1'b0, 1'b1, 32'h0,        4'h0, 32'h5, 1'b0};
    vecs[9]  = '{3'd1, 1'b1, 1'b0, 32'hF,        4'h0, 32'h5, 1'b0};
    vecs[10] = '{3'd0, 1'b1, 1'b0, 32'hF,        4'h0, 32'h0, 1'b0};
    vecs[11] = '{3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[12] = '{3'd5, 1'b1, 1'b0, 32'hF,        4'h0, 32'h0, 1'b0};
    vecs[13] = '{3'd5, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[14] = '{3'd6, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    vecs[15] = '{3'd7, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd, vecs[i].inp);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_irq);
    end

    // Latency: 0x0 -> 0x5 sampled at edge N, IRQ_MASK = 0x1.
    applyStimulus(3'd0, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("lat_n",   32'h0, 1'b0);
    applyStimulus(3'd0, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("lat_n1",  32'h0, 1'b0);
    applyStimulus(3'd0, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("lat_n2",  32'h5, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("lat_n3",  32'h5, 1'b1);
    applyStimulus(3'd3, 1'b1, 1'b0, 32'h1, 4'h5); checkOutput("w1c",     32'h5, 1'b1);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("w1c_next", 32'h4, 1'b0);

    // FALL_EN = 0: falling bit 2 is ignored, then a rising bit 2 captures.
    applyStimulus(3'd4, 1'b1, 1'b0, 32'h0, 4'h5); checkOutput("fall_wr", 32'hF, 1'b0);
    applyStimulus(3'd3, 1'b1, 1'b0, 32'hF, 4'h5); checkOutput("clr_all", 32'h4, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("clr_done", 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h1);
      checkOutput($sformatf("fall_off%0d", i), 32'h0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h5);
      checkOutput($sformatf("rise_wait%0d", i), 32'h0, 1'b0);
    end
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h5); checkOutput("rise_b2", 32'h4, 1'b0);

    // W1C of bit 1 in the very cycle bit 1 gets a rising edge: set wins.
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h7); checkOutput("sim_a", 32'h4, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h7); checkOutput("sim_b", 32'h4, 1'b0);
    applyStimulus(3'd3, 1'b1, 1'b0, 32'h2, 4'h7); checkOutput("sim_c", 32'h4, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h7); checkOutput("sim_set", 32'h6, 1'b0);
    applyStimulus(3'd3, 1'b1, 1'b0, 32'h6, 4'h7); checkOutput("sim_clr", 32'h6, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h7); checkOutput("sim_zero", 32'h0, 1'b0);

    // Mask off/on with capture = 0x8.
    applyStimulus(3'd2, 1'b1, 1'b0, 32'h8, 4'h7); checkOutput("mask8", 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'hF);
      checkOutput($sformatf("b3_wait%0d", i), 32'h0, 1'b0);
    end
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'hF); checkOutput("b3_irq",   32'h8, 1'b1);
    applyStimulus(3'd2, 1'b1, 1'b0, 32'h0, 4'hF); checkOutput("mask_off", 32'h8, 1'b1);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'hF); checkOutput("irq_drop", 32'h8, 1'b0);
    applyStimulus(3'd2, 1'b1, 1'b0, 32'h8, 4'hF); checkOutput("mask_on",  32'h0, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'hF); checkOutput("irq_back", 32'h8, 1'b1);

    // Asynchronous reset while irq is high clears outputs without a clock.
    reset_n = 1'b0;
    #2;
    checkOutput("async_rst", 32'h0, 1'b0);
    doReset();
    applyStimulus(3'd1, 1'b0, 1'b1, 32'h0, 4'h0); checkOutput("post_rst_rise", 32'hF, 1'b0);
    applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 4'h0); checkOutput("post_rst_cap",  32'h0, 1'b0);

    // Randomised traffic against the reference model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] inp;
      inp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : hist[0];
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, inp);
      checkOutput($sformatf("rand%0d", i), m_rd, m_irq);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
